// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer with one outstanding memory read and a 2-entry
// credit-controlled output FIFO; redirects flush stale work, bad fetch addresses halt with a sticky fault.
module imem_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] MEM_SIZE = 64'd4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        busy,
    output logic        fault
);
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d, inf_pc_q, inf_pc_d;
    logic        inflight_q, inflight_d, fault_q, fault_d;
    logic [1:0]  count_q, count_d;
    logic [63:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
    logic [31:0] e0_ins_q, e0_ins_d, e1_ins_q, e1_ins_d;
    logic        pop, push, flush, credit, pc_bad, try_issue, issue;
    logic [1:0]  wr_idx;
    assign imem_addr = pc_q;
    assign out_valid = count_q != 2'd0;
    assign out_pc    = e0_pc_q;
    assign out_instr = e0_ins_q;
    assign busy      = state_q == FETCH;
    assign fault     = fault_q;
    always_comb begin
        pop       = out_valid && out_ready;
        flush     = state_q == FETCH && redirect_valid;
        // Outstanding work after this edge must fit in the two FIFO slots.
        credit    = ({1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
        pc_bad    = pc_q[1:0] != 2'b00 || ({1'b0, pc_q} + 65'd3) >= {1'b0, MEM_SIZE};
        try_issue = state_q == FETCH && !redirect_valid && credit;
        issue     = try_issue && !pc_bad;
        push      = inflight_q && !flush;
        wr_idx    = count_q - {1'b0, pop};
        state_d   = state_q;
        fault_d   = fault_q;
        pc_d      = pc_q;
        if (state_q == IDLE) begin
            if (redirect_valid) pc_d = redirect_pc;
            else if (start) state_d = FETCH;
        end
        if (flush) pc_d = redirect_pc;
        if (try_issue && pc_bad) begin
            state_d = HALT;
            fault_d = 1'b1;
        end
        if (issue) pc_d = pc_q + 64'd4;
        inflight_d = issue;
        inf_pc_d   = issue ? pc_q : inf_pc_q;
        count_d    = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        e0_pc_d    = pop ? e1_pc_q : e0_pc_q;
        e0_ins_d   = pop ? e1_ins_q : e0_ins_q;
        e1_pc_d    = e1_pc_q;
        e1_ins_d   = e1_ins_q;
        if (push && wr_idx[0]) begin
            e1_pc_d  = inf_pc_q;
            e1_ins_d = imem_instr;
        end
        if (push && !wr_idx[0]) begin
            e0_pc_d  = inf_pc_q;
            e0_ins_d = imem_instr;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inf_pc_q   <= 64'h0;
            inflight_q <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= 2'd0;
            e0_pc_q    <= 64'h0;
            e0_ins_q   <= 32'h0;
            e1_pc_q    <= 64'h0;
            e1_ins_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inf_pc_q   <= inf_pc_d;
            inflight_q <= inflight_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
            e0_pc_q    <= e0_pc_d;
            e0_ins_q   <= e0_ins_d;
            e1_pc_q    <= e1_pc_d;
            e1_ins_q   <= e1_ins_d;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed stimulus, queue-based reference model checked every cycle, plus literal pins.
module tb_imem_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        busy;
    logic        fault;
    int n_cmp = 0;
    int n_fail = 0;
    int n_xfer = 0;
    int x0;
    imem_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .busy(busy), .fault(fault)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] word(input logic [63:0] a);
        return (a < 64'd16) ? 32'h0000_0013 : (32'h1000_0000 | a[31:0]);
    endfunction
    always @(posedge clk) imem_instr <= word(imem_addr);
    always @(posedge clk) if (rst_n && out_valid && out_ready) n_xfer++;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask
    typedef struct {logic [63:0] pc; logic [31:0] ins;} ent_t;
    ent_t        q[$];
    int          m_st;
    logic [63:0] m_pc, m_ipc;
    bit          m_inf, m_fault;
    // Model: 0 idle, 1 fetching, 2 halted; delivered words come from the address, not the memory port.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_st = 0; m_pc = 64'h0; m_ipc = 64'h0; m_inf = 0; m_fault = 0;
        end else begin
            int  sz;
            bit  pop, inf;
            sz  = q.size();
            pop = sz > 0 && out_ready;
            inf = m_inf;
            m_inf = 0;
            if (pop) void'(q.pop_front());
            if (m_st == 1 && redirect_valid) begin
                q.delete();
                m_pc = redirect_pc;
            end else begin
                if (inf) q.push_back('{m_ipc, word(m_ipc)});
                if (m_st == 0) begin
                    if (redirect_valid) m_pc = redirect_pc;
                    else if (start) m_st = 1;
                end else if (m_st == 1 && sz + int'(inf) - int'(pop) < 2) begin
                    if (m_pc[1:0] != 0 || m_pc > 64'd4091) begin
                        m_st = 2;
                        m_fault = 1;
                    end else begin
                        m_inf = 1;
                        m_ipc = m_pc;
                        m_pc = m_pc + 4;
                    end
                end
            end
        end
    end
    always @(negedge clk) begin
        chk("model_out_valid", {63'h0, out_valid}, {63'h0, q.size() != 0});
        if (q.size() != 0) begin
            chk("model_out_pc", out_pc, q[0].pc);
            chk("model_out_instr", {32'h0, out_instr}, {32'h0, q[0].ins});
        end
        chk("model_imem_addr", imem_addr, m_pc);
        chk("model_busy", {63'h0, busy}, {63'h0, m_st == 1});
        chk("model_fault", {63'h0, fault}, {63'h0, m_fault});
    end
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask
    initial begin
        tick(2);
        rst_n = 1'b1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_imem_addr", imem_addr, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_fault", {63'h0, fault}, 64'h0);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_instr", {32'h0, out_instr}, 64'h0);
        out_ready = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_busy", {63'h0, busy}, 64'h1);
        chk("lat_e0_valid", {63'h0, out_valid}, 64'h0);
        tick();
        chk("lat_e1_valid", {63'h0, out_valid}, 64'h0);
        chk("lat_e1_addr", imem_addr, 64'h4);
        tick();
        chk("lat_e2_valid", {63'h0, out_valid}, 64'h1);
        chk("stream_pc0", out_pc, 64'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("stream_valid", {63'h0, out_valid}, 64'h1);
            chk("stream_pc", out_pc, 64'(4 * i));
            chk("stream_instr", {32'h0, out_instr}, 64'h13);
        end
        out_ready = 1'b0;
        tick(5);
        chk("stall_head", out_pc, 64'd12);
        chk("stall_addr", imem_addr, 64'd20);
        out_ready = 1'b1;
        tick();
        chk("resume_pc16", out_pc, 64'd16);
        tick();
        chk("resume_pc20", out_pc, 64'd20);
        out_ready = 1'b0;
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("redir_flushed", {63'h0, out_valid}, 64'h0);
        chk("redir_addr", imem_addr, 64'h40);
        tick();
        chk("redir_r1_valid", {63'h0, out_valid}, 64'h0);
        tick();
        chk("redir_pc", out_pc, 64'h40);
        chk("redir_instr", {32'h0, out_instr}, 64'h1000_0040);
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc = 64'h42;
        tick();
        redirect_valid = 1'b0;
        chk("mis_pre_fault", {63'h0, fault}, 64'h0);
        chk("mis_addr", imem_addr, 64'h42);
        tick();
        chk("mis_fault", {63'h0, fault}, 64'h1);
        chk("mis_busy", {63'h0, busy}, 64'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h0;
        tick();
        redirect_valid = 1'b0;
        tick(2);
        chk("halt_fault", {63'h0, fault}, 64'h1);
        chk("halt_busy", {63'h0, busy}, 64'h0);
        chk("halt_addr", imem_addr, 64'h42);
        do_reset();
        chk("clr_fault", {63'h0, fault}, 64'h0);
        chk("clr_addr", imem_addr, 64'h0);
        redirect_valid = 1'b1;
        redirect_pc = 64'd4080;
        tick();
        redirect_valid = 1'b0;
        chk("idle_redir_addr", imem_addr, 64'd4080);
        chk("idle_redir_busy", {63'h0, busy}, 64'h0);
        x0 = n_xfer;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(10);
        chk("end_fault", {63'h0, fault}, 64'h1);
        chk("end_addr", imem_addr, 64'd4092);
        chk("end_xfers", 64'(n_xfer - x0), 64'd3);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(4);
        chk("mid_valid", {63'h0, out_valid}, 64'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {63'h0, out_valid}, 64'h0);
        chk("async_busy", {63'h0, busy}, 64'h0);
        tick();
        rst_n = 1'b1;
        x0 = n_xfer;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_valid", {63'h0, out_valid}, 64'h0);
        end
        chk("post_rst_xfers", 64'(n_xfer - x0), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, first fetch address after start.
REQ-002 SHALL have parameter MEM_SIZE, default 4095, instruction memory size in bytes; used for range check.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins fetching from current PC.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  64  redirect target byte address.
REQ-008 SHALL have port imem_addr  output  64  byte address to instruction memory; equals internal PC register (combinational from register).
REQ-009 SHALL have port imem_instr  input  32  instruction memory read data, valid one cycle after imem_addr is sampled.
REQ-010 SHALL have port out_valid  output  1  fetched instruction available.
REQ-011 SHALL have port out_ready  input  1  decode accepts; transfer when out_valid && out_ready.
REQ-012 SHALL have port out_pc  output  64  address of the instruction at FIFO head.
REQ-013 SHALL have port out_instr  output  32  instruction at FIFO head.
REQ-014 SHALL have port busy  output  1  high in FETCH state.
REQ-015 SHALL have port fault  output  1  sticky fetch-address fault.

Function
REQ-016 SHALL implement states IDLE, FETCH, HALT; reset state IDLE.
REQ-017 IDLE: no issue; start -> FETCH; redirect_valid loads PC, stays IDLE.
REQ-018 FETCH: issue = credit available and no redirect this cycle; on issue, inflight <= 1, inflight_pc <= PC, PC <= PC+4 (64-bit wrap).
REQ-019 Response: when inflight==1 and not flushed, {inflight_pc, imem_instr} SHALL be pushed into a 2-entry output FIFO at next edge.
REQ-020 Credit: issue allowed only when (count + inflight - pop) < 2, pop = out_valid && out_ready; FIFO SHALL never overflow.
REQ-021 out_valid = (count != 0); out_pc/out_instr = head entry; head stable while out_valid && !out_ready.
REQ-022 Sustained throughput SHALL be 1 instruction/cycle with out_ready held high.
REQ-023 Redirect in FETCH (priority over issue and push): handshake that cycle completes normally; remaining FIFO entries and inflight response discarded; PC <= redirect_pc; issue resumes next cycle.
REQ-024 Fault: any PC about to be issued with PC[1:0] != 0 or PC+3 >= MEM_SIZE SHALL not be issued; state -> HALT, fault <= 1.
REQ-025 HALT: no issue; FIFO entries already held remain drainable; start and redirect ignored; exit only via reset.
REQ-026 start while in FETCH or HALT SHALL be ignored.
REQ-027 Latency: start sampled at edge E -> imem_addr=RESET_PC issued at E+1 -> out_valid=1, out_pc=RESET_PC after E+2.

Reset
REQ-028 rst_n low SHALL immediately set state IDLE, PC=RESET_PC, inflight=0, count=0, out_valid=0, busy=0, fault=0, out_pc=0, out_instr=0.
REQ-029 Reset mid-operation SHALL discard in-flight and buffered instructions; no transfer after rst_n release until a new start.

Verification
REQ-030 Reset, start, out_ready=1, memory holds words 0x00000013 at 0..12 -> out_pc 0,4,8,12 on consecutive cycles, first out_valid 2 cycles after start.
REQ-031 out_ready=0 for 5 cycles during streaming -> count saturates at 2, imem_addr holds, no loss/duplication; release -> in-order resume.
REQ-032 redirect_valid with redirect_pc=0x40 while FIFO full and inflight -> stale entries dropped, next out_pc=0x40.
REQ-033 redirect_pc=0x42 -> fault=1, state HALT, no further issue; start ignored; rst_n clears fault.
REQ-034 Stream to PC=MEM_SIZE-3 region (e.g. 4092 with MEM_SIZE=4095) -> fault at that PC, preceding instructions delivered.
REQ-035 rst_n asserted mid-stream asynchronously -> out_valid=0 immediately, no out_valid until next start.
